// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: streams host elements into two operand banks, then kicks the systolic array
module matrix_operand_loader #(
  parameter int ARRAY_SIZE   = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_MATRICES = 2,
  localparam int DEPTH       = ARRAY_SIZE * MAX_MATRICES,
  localparam int ADDR_W      = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_req,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic signed [DATA_WIDTH-1:0]       s_data,
  input  logic [ADDR_W-1:0]                  addr_matrix_A,
  input  logic [ADDR_W-1:0]                  addr_matrix_B,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0]   MATRIX_A_COL,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0]   MATRIX_B_ROW,
  output logic                               array_start,
  input  logic                               array_done,
  output logic                               loader_busy,
  output logic                               seq_done
);
  localparam int WORD_W = DATA_WIDTH * ARRAY_SIZE;
  localparam int LANE_W = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, KICK, RUN} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [LANE_W-1:0]               r_lane;
  logic [ADDR_W-1:0]               r_word;
  logic [DATA_WIDTH*(ARRAY_SIZE-1)-1:0] r_pack;
  logic [WORD_W-1:0]               r_bank_a [DEPTH];
  logic [WORD_W-1:0]               r_bank_b [DEPTH];
  logic                            r_seq_done;
  logic                            w_xfer;
  logic                            w_last_lane;
  logic                            w_last_word;
  logic                            w_wr;
  logic                            w_enter;

  assign s_ready      = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign array_start  = r_state == KICK;
  assign loader_busy  = r_state != IDLE;
  assign seq_done     = r_seq_done;
  assign w_xfer       = s_valid && s_ready;
  assign w_last_lane  = r_lane == LANE_W'(ARRAY_SIZE - 1);
  assign w_last_word  = r_word == ADDR_W'(DEPTH - 1);
  assign w_wr         = w_xfer && w_last_lane;
  assign w_enter      = (w_next != r_state) && ((w_next == LOAD_A) || (w_next == LOAD_B));
  assign MATRIX_A_COL = (int'(addr_matrix_A) < DEPTH) ? r_bank_a[addr_matrix_A] : '0;
  assign MATRIX_B_ROW = (int'(addr_matrix_B) < DEPTH) ? r_bank_b[addr_matrix_B] : '0;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state: each bank finishes on the write of its last word
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = load_req ? LOAD_A : IDLE;
      LOAD_A:  w_next = (w_wr && w_last_word) ? LOAD_B : LOAD_A;
      LOAD_B:  w_next = (w_wr && w_last_word) ? KICK : LOAD_B;
      KICK:    w_next = RUN;
      RUN:     w_next = array_done ? IDLE : RUN;
      default: w_next = IDLE;
    endcase
  end

  // lane/word counters and pack register, cleared whenever a bank load begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_word <= '0;
      r_pack <= '0;
    end else if (w_enter) begin
      r_lane <= '0;
      r_word <= '0;
      r_pack <= '0;
    end else if (w_xfer) begin
      r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
      if (!w_last_lane) r_pack[int'(r_lane)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
      if (w_last_lane) r_word <= w_last_word ? '0 : r_word + 1'b1;
    end
  end

  // operand banks: the final lane arrives live and is merged with the packed lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank_a[i] <= '0;
        r_bank_b[i] <= '0;
      end
    end else if (w_wr) begin
      if (r_state == LOAD_A) r_bank_a[r_word] <= {s_data, r_pack};
      if (r_state == LOAD_B) r_bank_b[r_word] <= {s_data, r_pack};
    end
  end

  // completion pulse lines up with the first IDLE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_seq_done <= 1'b0;
    else        r_seq_done <= (r_state == RUN) && array_done;
  end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: randomized load sequences checked against a bank-content model
module tb_matrix_operand_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic [2:0]  addr_matrix_A = '0;
  logic [2:0]  addr_matrix_B = '0;
  logic [23:0] MATRIX_A_COL;
  logic [23:0] MATRIX_B_ROW;
  logic        array_start;
  logic        array_done = 1'b0;
  logic        loader_busy;
  logic        seq_done;

  int          n_chk = 0;
  int          n_err = 0;
  logic [23:0] m_a [8];
  logic [23:0] m_b [8];
  logic [7:0]  pk [3];

  always #5 clk = ~clk;

  matrix_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .addr_matrix_A(addr_matrix_A), .addr_matrix_B(addr_matrix_B),
    .MATRIX_A_COL(MATRIX_A_COL), .MATRIX_B_ROW(MATRIX_B_ROW), .array_start(array_start),
    .array_done(array_done), .loader_busy(loader_busy), .seq_done(seq_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // element k of a sequence: first 18 go to bank A, rest to bank B, 3 lanes per word
  function automatic void model_accept(input int k, input logic [7:0] d);
    int idx, lane, word;
    idx  = k % 18;
    lane = idx % 3;
    word = idx / 3;
    pk[lane] = d;
    if (lane == 2) begin
      if (k < 18) m_a[word] = {pk[2], pk[1], pk[0]};
      else        m_b[word] = {pk[2], pk[1], pk[0]};
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
  endfunction

  // mode 0: 1..36 back-to-back, 1: toggled valid random data, 2: 101..136, 3: random valid/data
  task automatic run_load(input int mode, input int abort_at);
    int n, cyc;
    logic v;
    logic [7:0] d;
    n = 0;
    cyc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    load_req = 1'b1;
    #1;
    chk("idle_ready", 32'(s_ready), 0);
    chk("idle_busy", 32'(loader_busy), 0);
    @(negedge clk);
    load_req = 1'b0;
    while (n < 36 && n != abort_at && cyc < 2000) begin
      v = (mode == 0 || mode == 2) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
      d = (mode == 0) ? 8'(n + 1) : (mode == 2) ? 8'(101 + n) : 8'($urandom);
      s_valid = v;
      s_data = d;
      addr_matrix_A = (n == 8 || n == 9) ? 3'd2 : 3'($urandom_range(0, 7));
      addr_matrix_B = 3'($urandom_range(0, 7));
      #1;
      chk("load_ready", 32'(s_ready), 1);
      chk("load_start", 32'(array_start), 0);
      chk("load_busy", 32'(loader_busy), 1);
      chk("rd_a", 32'(MATRIX_A_COL), 32'(m_a[addr_matrix_A]));
      chk("rd_b", 32'(MATRIX_B_ROW), 32'(m_b[addr_matrix_B]));
      if (v) begin
        model_accept(n, d);
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (cyc >= 2000) chk("load_timeout", 0, 1);
    if (n == abort_at) return;
    #1;
    chk("kick_start", 32'(array_start), 1);
    chk("kick_ready", 32'(s_ready), 0);
    chk("kick_busy", 32'(loader_busy), 1);
    @(negedge clk);
    load_req = 1'b1;
    #1;
    chk("run_start", 32'(array_start), 0);
    chk("run_ready", 32'(s_ready), 0);
    @(negedge clk);
    load_req = 1'b0;
    #1;
    chk("run_req_ignored_busy", 32'(loader_busy), 1);
    chk("run_req_ignored_ready", 32'(s_ready), 0);
  endtask

  task automatic finish_run();
    int w;
    w = $urandom_range(0, 5);
    repeat (w) begin
      @(negedge clk);
      #1;
      chk("run_busy", 32'(loader_busy), 1);
      chk("run_seq", 32'(seq_done), 0);
    end
    @(negedge clk);
    array_done = 1'b1;
    #1;
    chk("pre_done_seq", 32'(seq_done), 0);
    @(negedge clk);
    array_done = 1'b0;
    #1;
    chk("done_seq", 32'(seq_done), 1);
    chk("done_busy", 32'(loader_busy), 0);
    @(negedge clk);
    #1;
    chk("done_seq_once", 32'(seq_done), 0);
  endtask

  task automatic check_banks();
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      addr_matrix_A = 3'(a);
      addr_matrix_B = 3'(7 - a);
      #1;
      chk("bank_a", 32'(MATRIX_A_COL), 32'(m_a[a]));
      chk("bank_b", 32'(MATRIX_B_ROW), 32'(m_b[7 - a]));
    end
  endtask

  task automatic check_first_words(input logic [23:0] ea, input logic [23:0] eb);
    @(negedge clk);
    addr_matrix_A = 3'd0;
    addr_matrix_B = 3'd0;
    #1;
    chk("a_word0", 32'(MATRIX_A_COL), 32'(ea));
    chk("b_word0", 32'(MATRIX_B_ROW), 32'(eb));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(s_ready), 0);
    chk({tag, "_start"}, 32'(array_start), 0);
    chk({tag, "_busy"}, 32'(loader_busy), 0);
    chk({tag, "_seq"}, 32'(seq_done), 0);
    for (int a = 0; a < 6; a++) begin
      addr_matrix_A = 3'(a);
      addr_matrix_B = 3'(a);
      #1;
      chk({tag, "_rd_a"}, 32'(MATRIX_A_COL), 0);
      chk({tag, "_rd_b"}, 32'(MATRIX_B_ROW), 0);
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    run_load(0, -1);
    check_first_words(24'h030201, 24'h151413);
    finish_run();
    check_banks();
    @(negedge clk);
    array_done = 1'b1;
    @(negedge clk);
    array_done = 1'b0;
    #1;
    chk("idle_done_busy", 32'(loader_busy), 0);
    chk("idle_done_seq", 32'(seq_done), 0);
    chk("idle_done_start", 32'(array_start), 0);
    run_load(1, -1);
    finish_run();
    check_banks();
    run_load(3, 10);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("midrst");
    run_load(0, -1);
    check_first_words(24'h030201, 24'h151413);
    finish_run();
    check_banks();
    run_load(2, -1);
    check_first_words(24'h676665, 24'h79_78_77);
    finish_run();
    check_banks();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
